// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   Data-memory bus seen by the UART transmitter.
//   master : processor side (drives addr/wdata/we/re, receives rdata/hit)
//   slave  : peripheral side (the reverse)
//   addr   32  processor data address
//   wdata  32  store data
//   we      1  store strobe
//   re      1  load strobe
//   rdata  32  registered load data
//   hit     1  rdata is valid for this peripheral
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, wdata, we, re, input rdata, hit);
  modport slave  (input addr, wdata, we, re, output rdata, hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. Stores to TXDATA push bytes into a
//   small FIFO; a serialiser drains it onto tx. Loads return status and the
//   baud divisor with one cycle of latency.
//   Register window (16 bytes at BASE_ADDR, addr[3:2] selects):
//     0x0 TXDATA  W  push wdata[7:0]; reads 0
//     0x4 STATUS  RW {count[8:4], overflow, busy, empty, full}; wdata[3]=1 clears overflow
//     0x8 BAUDDIV RW bits[15:0]; bit period is BAUDDIV+1 cycles
//     0xC reserved
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  slave side of the data-memory bus
//     tx   serial output, idles high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h10000000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  // Bus decode
  logic       sel;
  logic [1:0] regSel;
  logic       readEn;
  logic       txDataWr;
  logic       statusWr;
  logic       divWr;

  // FIFO and configuration state
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [4:0]       count;
  logic             overflow;
  logic [15:0]      baudDiv;

  // Serialiser state
  stateT       state;
  logic [15:0] divLatched;
  logic [15:0] divCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;

  logic        fifoFull;
  logic        fifoEmpty;
  logic        bitDone;
  logic        popNow;
  logic        pushNow;
  logic [31:0] readMux;

  // Bits of the bus this block never looks at.
  logic unusedBits;
  assign unusedBits = ^{bus.addr[1:0], bus.wdata[31:16]};

  assign sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign regSel   = bus.addr[3:2];
  assign readEn   = sel && bus.re;
  assign txDataWr = sel && bus.we && (regSel == 2'd0);
  assign statusWr = sel && bus.we && (regSel == 2'd1);
  assign divWr    = sel && bus.we && (regSel == 2'd2);

  assign fifoFull  = (count == DEPTH_CNT);
  assign fifoEmpty = (count == 5'd0);
  assign bitDone   = (divCnt == divLatched);

  // The serialiser pops from IDLE, or at the last cycle of a stop bit so the
  // next start bit follows with no idle gap.
  assign popNow  = !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitDone));
  // A full FIFO still accepts a byte when a pop frees the head slot this edge.
  assign pushNow = txDataWr && (!fifoFull || popNow);

  // Load data reflects the state before any store sampled on the same edge.
  always_comb begin
    readMux = 32'd0;
    case (regSel)
      2'd1:    readMux = {23'd0, count, overflow, (state != IDLE), fifoEmpty, fifoFull};
      2'd2:    readMux = {16'd0, baudDiv};
      default: readMux = 32'd0;
    endcase
  end

  // FIFO storage; pointers make stale contents unreachable after reset.
  always_ff @(posedge clk) begin
    if (!rst && pushNow) begin
      fifoMem[wrPtr] <= bus.wdata[7:0];
    end
  end

  // Bus registers, FIFO bookkeeping and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= 5'd0;
      overflow  <= 1'b0;
      baudDiv   <= DEFAULT_DIV;
      bus.rdata <= 32'd0;
      bus.hit   <= 1'b0;
    end else begin
      if (pushNow) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popNow) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushNow, popNow})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (txDataWr && !pushNow) begin
        overflow <= 1'b1;
      end else if (statusWr && bus.wdata[3]) begin
        overflow <= 1'b0;
      end
      if (divWr) begin
        baudDiv <= bus.wdata[15:0];
      end
      bus.hit   <= readEn;
      bus.rdata <= readEn ? readMux : 32'd0;
    end
  end

  // Serialiser: each bit lasts divLatched+1 cycles, counted by divCnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      divLatched <= 16'd0;
      divCnt     <= 16'd0;
      bitIdx     <= 3'd0;
      shiftReg   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (popNow) begin
            shiftReg   <= fifoMem[rdPtr];
            divLatched <= baudDiv;
            divCnt     <= 16'd0;
            state      <= START;
            tx         <= 1'b0;
          end
        end
        START: begin
          if (bitDone) begin
            divCnt <= 16'd0;
            bitIdx <= 3'd0;
            state  <= DATA;
            tx     <= shiftReg[0];
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            divCnt <= 16'd0;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
            end
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            divCnt <= 16'd0;
            if (popNow) begin
              shiftReg   <= fifoMem[rdPtr];
              divLatched <= baudDiv;
              state      <= START;
              tx         <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
